// File: rtl/ppudata_port_if.sv
// CPU register / VRAM / palette bus for the PPUADDR-PPUDATA access engine.
// master = register decoder + storage side, slave = ppudata_port.
interface ppudata_port_if;
  logic [2:0] reg_sel;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] cpu_data_in;
  logic       status_rd;
  logic       inc32;
  logic       mirroring;
  logic [7:0] cpu_data_out;
  logic       rd_valid;
  logic       busy;
  logic [9:0] vram_addr;
  logic       vram_page;
  logic [7:0] vram_data_out;
  logic [7:0] vram_data_in;
  logic       vram_wren;
  logic       vram_rden;
  logic [4:0] pal_addr;
  logic [7:0] pal_data_out;
  logic [7:0] pal_data_in;
  logic       pal_wren;
  logic       pal_rden;

  modport master (
    output reg_sel, cpu_wr, cpu_rd, cpu_data_in, status_rd, inc32, mirroring,
    output vram_data_in, pal_data_in,
    input  cpu_data_out, rd_valid, busy, vram_addr, vram_page, vram_data_out,
    input  vram_wren, vram_rden, pal_addr, pal_data_out, pal_wren, pal_rden
  );

  modport slave (
    input  reg_sel, cpu_wr, cpu_rd, cpu_data_in, status_rd, inc32, mirroring,
    input  vram_data_in, pal_data_in,
    output cpu_data_out, rd_valid, busy, vram_addr, vram_page, vram_data_out,
    output vram_wren, vram_rden, pal_addr, pal_data_out, pal_wren, pal_rden
  );
endinterface

// File: rtl/ppudata_port.sv
// PPUADDR/PPUDATA access engine: VRAM pointer, write toggle, read buffer, increment.
// Optional PALETTE_READ_DIRECT_EN: palette reads bypass the read buffer.
module ppudata_port #(
  parameter logic [13:0] RESET_ADDR = 14'h0000,
  parameter logic [7:0]  READ_FILL  = 8'h00
) (
  input  logic           clk,
  input  logic           reset,
  ppudata_port_if.slave  bus
);

`ifdef PALETTE_READ_DIRECT_EN
  localparam bit DIRECT_PAL = 1'b1;
`else
  localparam bit DIRECT_PAL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_CAP} state_t;

  state_t      state, state_next;
  logic [13:0] v, v_next;
  logic        w, w_next;
  logic [7:0]  buffer;
  logic [7:0]  wdata;
  logic [7:0]  rd_data;
  logic        rd_valid;

  logic is_pal, is_nt, direct_pal;
  logic addr_wr, data_wr, data_rd;

  assign is_pal     = (v[13:8] == 6'h3F);
  assign is_nt      = v[13] && !is_pal;
  assign direct_pal = DIRECT_PAL && is_pal;

  assign addr_wr = bus.cpu_wr && (bus.reg_sel == 3'd6);
  assign data_wr = bus.cpu_wr && (bus.reg_sel == 3'd7);
  assign data_rd = bus.cpu_rd && !bus.cpu_wr && (bus.reg_sel == 3'd7);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (data_wr) state_next = WR;
               else if (data_rd) state_next = RD_REQ;
      WR:      state_next = IDLE;
      RD_REQ:  state_next = RD_CAP;
      RD_CAP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A PPUADDR write landing on the last access cycle takes priority over the increment.
  always_comb begin
    v_next = v;
    w_next = w;
    if ((state == WR) || (state == RD_CAP))
      v_next = v + (bus.inc32 ? 14'd32 : 14'd1);
    if (addr_wr) begin
      if (!w) v_next = {bus.cpu_data_in[5:0], v[7:0]};
      else    v_next = {v[13:8], bus.cpu_data_in};
      w_next = !w;
    end
    if (bus.status_rd)
      w_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      v        <= RESET_ADDR;
      w        <= 1'b0;
      buffer   <= '0;
      wdata    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      v        <= v_next;
      w        <= w_next;
      rd_valid <= 1'b0;
      if ((state == IDLE) && data_wr)
        wdata <= bus.cpu_data_in;
      if ((state == IDLE) && data_rd && !data_wr && !direct_pal) begin
        rd_data  <= buffer;
        rd_valid <= 1'b1;
      end
      if (state == RD_CAP) begin
        if (direct_pal) begin
          rd_data  <= bus.pal_data_in;
          buffer   <= bus.vram_data_in;
          rd_valid <= 1'b1;
        end else if (is_nt) begin
          buffer <= bus.vram_data_in;
        end else if (is_pal) begin
          buffer <= bus.pal_data_in;
        end else begin
          buffer <= READ_FILL;
        end
      end
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.cpu_data_out = rd_data;
  assign bus.rd_valid     = rd_valid;

  assign bus.vram_wren = (state == WR) && is_nt;
  assign bus.pal_wren  = (state == WR) && is_pal;
  assign bus.vram_rden = (state == RD_REQ) && (is_nt || direct_pal);
  assign bus.pal_rden  = (state == RD_REQ) && is_pal;

  assign bus.vram_data_out = bus.vram_wren ? wdata : '0;
  assign bus.pal_data_out  = bus.pal_wren  ? wdata : '0;

  // Subtracting $1000 for the direct palette read leaves v[11:0] untouched,
  // so the nametable offset and page come straight from v in every case.
  assign bus.vram_addr = v[9:0];
  assign bus.vram_page = bus.mirroring ? v[11] : v[10];
  assign bus.pal_addr  = {v[4] & (v[1:0] != 2'b00), v[3:0]};

endmodule

// File: tb/tb_ppudata_port.sv
// Directed bench for ppudata_port with VRAM/palette storage models.
module tb_ppudata_port;
  logic clk = 1'b0;
  logic reset;
  int unsigned vectors = 0;
  int unsigned errs    = 0;

  logic [7:0] vmem [0:2047];
  logic [7:0] pmem [0:31];

  ppudata_port_if bus ();

  ppudata_port #(.RESET_ADDR(14'h0000), .READ_FILL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.vram_wren) vmem[{bus.vram_page, bus.vram_addr}] = bus.vram_data_out;
    if (bus.pal_wren)  pmem[bus.pal_addr] = bus.pal_data_out;
    if (bus.vram_rden) bus.vram_data_in <= vmem[{bus.vram_page, bus.vram_addr}];
    if (bus.pal_rden)  bus.pal_data_in  <= pmem[bus.pal_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [7:0] data);
    bus.reg_sel     = sel;
    bus.cpu_data_in = data;
    bus.cpu_wr      = 1'b1;
    tick();
    bus.cpu_wr      = 1'b0;
  endtask

  task automatic rd7();
    bus.reg_sel = 3'd7;
    bus.cpu_rd  = 1'b1;
    tick();
    bus.cpu_rd  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) vmem[i] = 8'h00;
    for (int i = 0; i < 32; i++)   pmem[i] = 8'h00;
    reset = 1'b1;
    bus.reg_sel = 3'd0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_data_in = 8'h00;
    bus.status_rd = 1'b0; bus.inc32 = 1'b0; bus.mirroring = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_data_out", bus.cpu_data_out, 8'h00);
    chk("rst_strobes", {bus.vram_wren, bus.vram_rden, bus.pal_wren, bus.pal_rden}, 4'h0);
    chk("rst_vram_addr", bus.vram_addr, 10'h000);
    reset = 1'b0;

    // address load $2108
    wr_reg(3'd6, 8'h21);
    wr_reg(3'd6, 8'h08);
    chk("load_addr", bus.vram_addr, 10'h108);
    chk("load_page_v", bus.vram_page, 1'b0);
    bus.mirroring = 1'b1; #1;
    chk("load_page_h", bus.vram_page, 1'b0);
    bus.mirroring = 1'b0;

    // writes with increment by 32 from $2000
    bus.inc32 = 1'b1;
    wr_reg(3'd6, 8'h20);
    wr_reg(3'd6, 8'h00);
    wr_reg(3'd7, 8'hAA);
    chk("wr1_wren", {bus.vram_wren, bus.pal_wren, bus.busy}, 3'b101);
    chk("wr1_addr", bus.vram_addr, 10'h000);
    chk("wr1_data", bus.vram_data_out, 8'hAA);
    tick();
    chk("wr1_idle", {bus.vram_wren, bus.busy}, 2'b00);
    chk("wr1_inc", bus.vram_addr, 10'h020);
    wr_reg(3'd7, 8'hBB);
    chk("wr2_wren", bus.vram_wren, 1'b1);
    chk("wr2_addr", bus.vram_addr, 10'h020);
    chk("wr2_data", bus.vram_data_out, 8'hBB);
    tick();
    chk("wr2_inc", bus.vram_addr, 10'h040);
    chk("wr_mem", vmem[11'h020], 8'hBB);

    // buffered reads from $2400
    bus.inc32 = 1'b0;
    vmem[11'h400] = 8'h55; vmem[11'h401] = 8'h66; vmem[11'h402] = 8'h77;
    wr_reg(3'd6, 8'h24);
    wr_reg(3'd6, 8'h00);
    rd7();
    chk("rd1_data", bus.cpu_data_out, 8'h00);
    chk("rd1_valid", bus.rd_valid, 1'b1);
    chk("rd1_rden", {bus.vram_rden, bus.pal_rden, bus.busy}, 3'b101);
    tick();
    chk("rd1_cap", {bus.rd_valid, bus.vram_rden, bus.busy}, 3'b001);
    tick();
    chk("rd1_done", {bus.busy, bus.vram_addr}, {1'b0, 10'h001});
    rd7();
    chk("rd2_data", bus.cpu_data_out, 8'h55);
    tick(); tick();
    rd7();
    chk("rd3_data", bus.cpu_data_out, 8'h66);
    tick(); tick();
    chk("rd_end_addr", {bus.vram_page, bus.vram_addr}, {1'b1, 10'h003});

    // status read resets the toggle; $3F10 aliases $3F00
    wr_reg(3'd6, 8'h3F);
    bus.status_rd = 1'b1;
    tick();
    bus.status_rd = 1'b0;
    wr_reg(3'd6, 8'h3F);
    wr_reg(3'd6, 8'h10);
    chk("alias_addr", bus.pal_addr, 5'h00);
    wr_reg(3'd7, 8'h0F);
    chk("pal_wr", {bus.pal_wren, bus.vram_wren}, 2'b10);
    chk("pal_wr_data", {bus.pal_addr, bus.pal_data_out}, {5'h00, 8'h0F});
    tick();
    chk("pal_inc", bus.pal_addr, 5'h11);

    // wrap $3FFF -> $0000 and drop a write while busy
    wr_reg(3'd6, 8'h3F);
    wr_reg(3'd6, 8'hFF);
    wr_reg(3'd7, 8'h12);
    chk("wrap_wr", {bus.pal_wren, bus.pal_addr}, {1'b1, 5'h1F});
    wr_reg(3'd7, 8'h34);
    chk("wrap_v", {bus.busy, bus.vram_addr, bus.pal_addr}, {1'b0, 10'h000, 5'h00});
    tick();
    chk("drop_no_strobe", {bus.vram_wren, bus.pal_wren, bus.busy}, 3'b000);
    chk("drop_no_inc", bus.vram_addr, 10'h000);

    // CHR write: busy, no strobe
    wr_reg(3'd7, 8'h56);
    chk("chr_wr", {bus.busy, bus.vram_wren, bus.pal_wren}, 3'b100);
    tick();
    chk("chr_inc", bus.vram_addr, 10'h001);

    // CHR reads: old buffer out, then READ_FILL
    rd7();
    chk("chr_rd1", bus.cpu_data_out, 8'h77);
    chk("chr_rd1_strobes", {bus.vram_rden, bus.pal_rden}, 2'b00);
    tick(); tick();
    rd7();
    chk("chr_rd2", bus.cpu_data_out, 8'h00);
    tick(); tick();

    // reset mid-access
    wr_reg(3'd6, 8'h20);
    wr_reg(3'd6, 8'h05);
    wr_reg(3'd7, 8'h99);
    chk("mid_wren", bus.vram_wren, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_abort", {bus.vram_wren, bus.busy, bus.vram_addr}, {2'b00, 10'h000});

    // write and read together: write wins
    wr_reg(3'd6, 8'h20);
    wr_reg(3'd6, 8'h10);
    bus.reg_sel = 3'd7; bus.cpu_data_in = 8'hC3;
    bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    chk("wr_wins", {bus.vram_wren, bus.vram_rden, bus.rd_valid, bus.vram_data_out}, {3'b100, 8'hC3});
    tick();
    chk("wr_wins_inc", bus.vram_addr, 10'h011);

`ifdef PALETTE_READ_DIRECT_EN
    pmem[5'h01] = 8'h21;
    vmem[11'h701] = 8'h77;
    wr_reg(3'd6, 8'h3F);
    wr_reg(3'd6, 8'h01);
    rd7();
    chk("dir_req", {bus.pal_rden, bus.vram_rden, bus.rd_valid}, 3'b110);
    tick();
    chk("dir_cap", bus.rd_valid, 1'b0);
    tick();
    chk("dir_data", {bus.rd_valid, bus.cpu_data_out}, {1'b1, 8'h21});
    wr_reg(3'd6, 8'h20);
    wr_reg(3'd6, 8'h00);
    rd7();
    chk("dir_buf", bus.cpu_data_out, 8'h77);
    tick(); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ppudata_port.md
Name: ppudata_port

Overview:
- CPU-facing PPUADDR ($2006) and PPUDATA ($2007) access engine.
- Initiates read and write cycles to the nametable VRAM and to palette RAM.
- Owns the 14-bit VRAM address pointer, the write-toggle latch, the PPUDATA read buffer and the post-access increment.
- Sits between the PPU register decoder and the VRAM / palette storage blocks.

Parameters:
- RESET_ADDR, 14'h0000, pointer value after reset.
- READ_FILL, 8'h00, byte loaded into the read buffer for $0000-$1FFF reads (no CHR path in this block).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reg_sel  in  3  CPU register index; 6=PPUADDR, 7=PPUDATA, others ignored
- cpu_wr  in  1  one-cycle CPU write strobe
- cpu_rd  in  1  one-cycle CPU read strobe
- cpu_data_in  in  8  CPU write data
- status_rd  in  1  PPUSTATUS read strobe; clears the write toggle
- inc32  in  1  PPUCTRL bit 2; 1 = increment by 32, 0 = increment by 1
- mirroring  in  1  0 = vertical, 1 = horizontal
- cpu_data_out  out  8  registered PPUDATA read result
- rd_valid  out  1  one-cycle pulse: cpu_data_out just updated
- busy  out  1  access in flight
- vram_addr  out  10  nametable offset, v[9:0]
- vram_page  out  1  physical page select
- vram_data_out  out  8  VRAM write data
- vram_data_in  in  8  VRAM read data, valid 1 cycle after vram_rden
- vram_wren, vram_rden  out  1  VRAM strobes
- pal_addr  out  5  palette index
- pal_data_out  out  8  palette write data
- pal_data_in  in  8  palette read data, valid 1 cycle after pal_rden
- pal_wren, pal_rden  out  1  palette strobes

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - v = RESET_ADDR; toggle w = 0; buffer = 8'h00; state = IDLE.
  - All outputs 0, except vram_addr/pal_addr/vram_page, which track v.
- Reset mid-access aborts the access: strobes drop next cycle; no increment.
- Decode: region is PAL if v[13:8]==6'h3F, NT if v[13] is set otherwise, CHR if v[13]==0.
- vram_page: mirroring ? v[11] : v[10].
- pal_addr: v[4:0], with bit 4 cleared when v[1:0]==0 ($3F10/14/18/1C alias $3F00/04/08/0C).
- PPUADDR write (reg_sel=6, cpu_wr):
  - w=0: v[13:8] = data[5:0]; w = 1.
  - w=1: v[7:0] = data; w = 0.
  - Accepted even while busy.
- status_rd clears w. If status_rd and a PPUADDR write occur in the same cycle, the write uses the old w, then w = 0.
- FSM states: IDLE, WR, RD_REQ, RD_CAP.
- IDLE + PPUDATA write → WR (1 cycle):
  - NT region: vram_wren=1, vram_data_out = data.
  - PAL region: pal_wren=1, pal_data_out = data.
  - CHR region: no strobe.
  - Then v += inc32 ? 32 : 1, modulo 2^14 ($3FFF+1 → $0000). Return to IDLE.
- IDLE + PPUDATA read:
  - Strobe cycle: cpu_data_out = buffer, and rd_valid pulses the next cycle.
  - → RD_REQ: vram_rden=1 if NT; pal_rden=1 if PAL.
  - → RD_CAP: buffer = vram_data_in (NT), pal_data_in (PAL, buffered mode) or READ_FILL (CHR); v increments.
  - → IDLE.
  - Read latency is 1 cycle; a full access holds busy for 2 cycles.
- busy = (state != IDLE).
- PPUDATA strobes arriving while busy are dropped: no state change, no increment.
- cpu_wr and cpu_rd asserted together: write wins.
- Only one of vram_wren, vram_rden, pal_wren, pal_rden is ever high in a given cycle.

Optional Feature:
- Macro: PALETTE_READ_DIRECT_EN.
- Defined:
  - A PAL-region read bypasses the buffer. RD_REQ asserts both pal_rden and vram_rden; vram_addr is taken from v-$1000 (the $2F00-$2FFF nametable underneath).
  - In RD_CAP: cpu_data_out = pal_data_in; buffer = vram_data_in; rd_valid pulses the cycle after RD_CAP. No rd_valid on the strobe cycle.
  - The one-strobe rule is waived for this case only.
- Undefined: palette reads are buffered like NT reads.

Test Plan:
- Address load: write $21 then $08 to reg 6, with inc32=0 → vram_addr=10'h108, vram_page=0 (mirroring=0) / 0 (mirroring=1).
- Write with increment: inc32=1, PPUDATA writes $AA then $BB at $2000 → vram_wren at offsets $000 and $020, v ends $2040.
- Buffered read: VRAM holds $55 at $2400, $66 at $2401; read reg 7 three times → cpu_data_out = $00, then $55, then $66; v ends $2403.
- Palette alias and toggle: status_rd between the two PPUADDR bytes resets w; write $0F to $3F10 → pal_wren with pal_addr=5'h00.
- Busy drop and wrap: set v=$3FFF, write → v=$0000; a second cpu_wr while busy → no strobe, no increment.
- Feature on: palette $3F01 holds $21, VRAM at $2F01 holds $77; read → cpu_data_out=$21 at RD_CAP+1; next read returns $77.
